// File: rtl/vending_credit_engine_pkg.sv
// vm_credit_pkg: shared FSM encoding and default coin/price/timer constants for the credit engine
package vm_credit_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, RETURN} state_e;
  localparam logic [47:0] DEF_COIN_VALUES = {16'd1000, 16'd500, 16'd100};
  localparam logic [63:0] DEF_ITEM_PRICES = {16'd2000, 16'd1000, 16'd500, 16'd400};
  localparam int DEF_WAIT_CYCLES = 10;
endpackage

// File: rtl/vending_credit_engine_if.sv
// vending_credit_engine_if: coin/select inputs, item/change outputs and the change hopper handshake
// master: engine side (drives o_*), slave: acceptor/dispenser/hopper side (drives i_*)
interface vending_credit_engine_if #(
  parameter int NUM_COINS = 3,
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W  = 16,
  parameter int TIMER_W   = 32
);
  logic [NUM_COINS-1:0] i_input_coin;
  logic [NUM_ITEMS-1:0] i_select_item;
  logic                 i_trigger_return;
  logic                 i_return_ready;
  logic [NUM_ITEMS-1:0] o_available_item;
  logic [NUM_ITEMS-1:0] o_output_item;
  logic [NUM_COINS-1:0] o_reject_coin;
  logic [NUM_COINS-1:0] o_return_coin;
  logic                 o_return_valid;
  logic [CREDIT_W-1:0]  o_credit;
  logic [TIMER_W-1:0]   o_wait_time;
  logic                 o_busy;
  modport master (
    input  i_input_coin, i_select_item, i_trigger_return, i_return_ready,
    output o_available_item, o_output_item, o_reject_coin, o_return_coin,
           o_return_valid, o_credit, o_wait_time, o_busy
  );
  modport slave (
    output i_input_coin, i_select_item, i_trigger_return, i_return_ready,
    input  o_available_item, o_output_item, o_reject_coin, o_return_coin,
           o_return_valid, o_credit, o_wait_time, o_busy
  );
endinterface

// File: rtl/vending_credit_engine_change_selector.sv
// change_selector: picks the largest coin whose value fits in the given credit
// credit_i: credit to pay out; coin_o: one-hot coin; value_o: its value; none_o: no coin fits
module change_selector
  import vm_credit_pkg::*;
#(
  parameter int NUM_COINS = 3,
  parameter int CREDIT_W  = 16,
  parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = DEF_COIN_VALUES
) (
  input  logic [CREDIT_W-1:0]  credit_i,
  output logic [NUM_COINS-1:0] coin_o,
  output logic [CREDIT_W-1:0]  value_o,
  output logic                 none_o
);
  // Values ascend with index, so the last fitting index scanned is the largest coin.
  always_comb begin
    coin_o = '0;
    value_o = '0;
    none_o = 1'b1;
    for (int i = 0; i < NUM_COINS; i++)
      if (COIN_VALUES[i*CREDIT_W +: CREDIT_W] <= credit_i) begin
        coin_o = '0;
        coin_o[i] = 1'b1;
        value_o = COIN_VALUES[i*CREDIT_W +: CREDIT_W];
        none_o = 1'b0;
      end
  end
endmodule

// File: rtl/vending_credit_engine.sv
// vending_credit_engine: credit accumulation, vending, inactivity timeout and one-coin-per-cycle change return
// clk/reset: clock and synchronous active-high reset; bus: coin/select/trigger/ready in, item/change/status out
module vending_credit_engine
  import vm_credit_pkg::*;
#(
  parameter int NUM_COINS   = 3,
  parameter int NUM_ITEMS   = 4,
  parameter int CREDIT_W    = 16,
  parameter int TIMER_W     = 32,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = DEF_COIN_VALUES,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICES = DEF_ITEM_PRICES
) (
  input logic clk,
  input logic reset,
  vending_credit_engine_if.master bus
);
  localparam int SUM_W = CREDIT_W + $clog2(NUM_COINS + 1);
  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(WAIT_CYCLES);
  state_e               state_q;
  logic [CREDIT_W-1:0]  credit_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [NUM_ITEMS-1:0] item_q, avail_q;
  logic [NUM_COINS-1:0] reject_q, ret_coin_q;
  logic                 ret_valid_q, busy_q;
  logic [SUM_W-1:0]     sum;
  logic [NUM_ITEMS-1:0] pick;
  logic [CREDIT_W-1:0]  price, credit_c, credit_p, sel_value;
  logic [NUM_COINS-1:0] sel_coin;
  logic                 sel_none, in_ret, ovf, accept, buy, reload, go_ret;
  function automatic logic [NUM_ITEMS-1:0] avail_of(input logic [CREDIT_W-1:0] c);
    logic [NUM_ITEMS-1:0] a;
    for (int j = 0; j < NUM_ITEMS; j++) a[j] = c >= ITEM_PRICES[j*CREDIT_W +: CREDIT_W];
    return a;
  endfunction
  // Wide sum so an overflowing insert is detected instead of wrapping; only the lowest select is kept.
  always_comb begin
    sum = SUM_W'(credit_q);
    for (int i = 0; i < NUM_COINS; i++)
      if (bus.i_input_coin[i]) sum = sum + SUM_W'(COIN_VALUES[i*CREDIT_W +: CREDIT_W]);
    pick = '0;
    price = '0;
    for (int j = NUM_ITEMS - 1; j >= 0; j--)
      if (bus.i_select_item[j]) begin
        pick = '0;
        pick[j] = 1'b1;
        price = ITEM_PRICES[j*CREDIT_W +: CREDIT_W];
      end
  end
  assign in_ret   = state_q == RETURN;
  assign ovf      = |sum[SUM_W-1:CREDIT_W];
  assign accept   = |bus.i_input_coin && !ovf;
  assign credit_c = accept ? sum[CREDIT_W-1:0] : credit_q;
  assign buy      = |pick && credit_c >= price;
  assign credit_p = buy ? credit_c - price : credit_c;
  assign reload   = accept | buy;
  // A trigger always wins; a timeout only counts when nothing reloaded the timer this cycle.
  assign go_ret   = credit_p != '0 && (bus.i_trigger_return || (state_q == ACTIVE && !reload && timer_q == '0));
  change_selector #(
    .NUM_COINS(NUM_COINS), .CREDIT_W(CREDIT_W), .COIN_VALUES(COIN_VALUES)
  ) u_sel (
    .credit_i(credit_q), .coin_o(sel_coin), .value_o(sel_value), .none_o(sel_none)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      credit_q <= '0;
      timer_q <= RELOAD;
      item_q <= '0;
      avail_q <= '0;
      reject_q <= '0;
      ret_coin_q <= '0;
      ret_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      item_q <= '0;
      reject_q <= (in_ret || ovf) ? bus.i_input_coin : '0;
      if (in_ret) begin
        // Offer, wait for ready, subtract, drop valid for a cycle, repeat until nothing fits.
        if (ret_valid_q) begin
          if (bus.i_return_ready) begin
            credit_q <= credit_q - sel_value;
            ret_valid_q <= 1'b0;
            ret_coin_q <= '0;
          end
        end else if (sel_none) begin
          state_q <= IDLE;
          credit_q <= '0;
          timer_q <= RELOAD;
          busy_q <= 1'b0;
          avail_q <= avail_of('0);
        end else begin
          ret_valid_q <= 1'b1;
          ret_coin_q <= sel_coin;
        end
      end else begin
        credit_q <= credit_p;
        item_q <= buy ? pick : '0;
        timer_q <= reload ? RELOAD : (state_q == ACTIVE && timer_q != '0) ? timer_q - TIMER_W'(1) : timer_q;
        state_q <= go_ret ? RETURN : credit_p == '0 ? IDLE : ACTIVE;
        busy_q <= go_ret;
        avail_q <= go_ret ? '0 : avail_of(credit_p);
      end
    end
  end
  assign bus.o_available_item = avail_q;
  assign bus.o_output_item    = item_q;
  assign bus.o_reject_coin    = reject_q;
  assign bus.o_return_coin    = ret_coin_q;
  assign bus.o_return_valid   = ret_valid_q;
  assign bus.o_credit         = credit_q;
  assign bus.o_wait_time      = timer_q;
  assign bus.o_busy           = busy_q;
endmodule
